// File: rtl/imm_ext_pkg.sv
// Shared opcodes, format codes and helpers for the immediate-extension stage.
// Imported by the decode core and the buffered top level.
package imm_ext_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_FENCE   = 7'b0001111;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_Z = 3'd6;

    localparam int BUF_DEPTH = 2;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/imm_ext_stage_if.sv
// Fetch-side push channel and decode-side pop channel of the immediate stage.
// The stage is the slave; the producer/consumer pair is the master.
interface imm_ext_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  immediate;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, instr, in_tag, out_ready,
        output in_ready, out_valid, immediate, fmt, illegal, out_tag
    );

    modport master (
        output in_valid, instr, in_tag, out_ready,
        input  in_ready, out_valid, immediate, fmt, illegal, out_tag
    );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational format decode and immediate extension of one instruction.
// Unsupported opcodes report illegal with format R and a zero immediate.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    logic [31:0] imm32;

    always_comb begin
        fmt_o     = FMT_R;
        illegal_o = 1'b0;
        case (instr_i[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_FENCE: fmt_o = FMT_I;
            OPC_OPIMM32: begin
                if (XLEN == 64) fmt_o = FMT_I;
                else            illegal_o = 1'b1;
            end
            OPC_STORE:          fmt_o = FMT_S;
            OPC_BRANCH:         fmt_o = FMT_B;
            OPC_LUI, OPC_AUIPC: fmt_o = FMT_U;
            OPC_JAL:            fmt_o = FMT_J;
            OPC_OP:             fmt_o = FMT_R;
            OPC_SYSTEM:         fmt_o = instr_i[14] ? FMT_Z : FMT_I;
            default:            illegal_o = 1'b1;
        endcase

        // Everything is formed as a 32-bit signed value; Z stays non-negative.
        imm32 = '0;
        case (fmt_o)
            FMT_I: imm32 = sext12(instr_i[31:20]);
            FMT_S: imm32 = sext12({instr_i[31:25], instr_i[11:7]});
            FMT_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U: imm32 = {instr_i[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            FMT_Z: imm32 = {27'b0, instr_i[19:15]};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate extender between fetch and decode with a 2-entry skid buffer.
// Extended fields are stored at push; in_ready depends only on the stored count.
module imm_ext_stage
    import imm_ext_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    imm_ext_stage_if.slave  bus
);

    if (DEPTH != BUF_DEPTH) begin : g_depth_chk
        $error("imm_ext_stage: DEPTH must be 2");
    end
    if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
        $error("imm_ext_stage: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] ext_imm;
    logic [2:0]      ext_fmt;
    logic            ext_ill;

    imm_ext_core #(.XLEN(XLEN)) u_core (
        .instr_i   (bus.instr),
        .imm_o     (ext_imm),
        .fmt_o     (ext_fmt),
        .illegal_o (ext_ill)
    );

    logic [XLEN-1:0]  imm_q [BUF_DEPTH];
    logic [2:0]       fmt_q [BUF_DEPTH];
    logic             ill_q [BUF_DEPTH];
    logic [TAG_W-1:0] tag_q [BUF_DEPTH];
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_comb begin
        wptr_d  = push ? ~wptr_q : wptr_q;
        rptr_d  = pop  ? ~rptr_q : rptr_q;
        count_d = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= '0;
                ill_q[i] <= 1'b0;
                tag_q[i] <= '0;
            end
        end else if (flush) begin
            // Stored payloads are left as-is; they are unobservable once count is 0.
            count_q <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
        end else begin
            if (push) begin
                imm_q[wptr_q] <= ext_imm;
                fmt_q[wptr_q] <= ext_fmt;
                ill_q[wptr_q] <= ext_ill;
                tag_q[wptr_q] <= bus.in_tag;
            end
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    assign bus.immediate = imm_q[rptr_q];
    assign bus.fmt       = fmt_q[rptr_q];
    assign bus.illegal   = ill_q[rptr_q];
    assign bus.out_tag   = tag_q[rptr_q];

endmodule
